// File: rtl/pong_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_pkg                                                                 |
// | Shared LED bus layout, coordinate widths and scanner types for pong.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pong_pkg;

  localparam int X_W   = 3;
  localparam int Y_W   = 4;
  localparam int LED_W = 10;

  localparam int LED_COL_LSB = 0;
  localparam int LED_ROW_LSB = 3;
  localparam int LED_CLR_LSB = 8;

  localparam logic [1:0] LED_BAR  = 2'b10;
  localparam logic [1:0] LED_BALL = 2'b01;

  localparam int BAR1_Y_DEF  = 12;
  localparam int BAR2_Y_DEF  = 3;
  localparam int BAR_LEN_DEF = 3;

  typedef enum logic [0:0] {
    LATCH = 1'b0,
    SCAN  = 1'b1
  } scan_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit 7 stays zero: it is reserved on the matrix bus.
  function automatic logic [LED_W-1:0] led_pixel(input logic [1:0]     clr,
                                                 input logic [Y_W-1:0] row,
                                                 input logic [X_W-1:0] col);
    logic [LED_W-1:0] v;
    v = '0;
    v[LED_CLR_LSB +: 2]   = clr;
    v[LED_ROW_LSB +: Y_W] = row;
    v[LED_COL_LSB +: X_W] = col;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_slot_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_slot_timer                                                          |
// | Dwell/slot counters for the LED scanner with look-ahead of next values.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scan_slot_timer
  import pong_pkg::*;
#(
  parameter int DWELL       = 2000,
  parameter int GUARD       = 1,
  parameter int FRAME_SLOTS = 128,
  localparam int DW_W       = cnt_w(DWELL),
  localparam int SLOT_W     = cnt_w(FRAME_SLOTS)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              run,
  output logic [SLOT_W-1:0] slot_nxt,
  output logic              guard_nxt,
  output logic              dwell_last,
  output logic              slot_last,
  output logic              last_nxt
);

  logic [DW_W-1:0]   r_dwell;
  logic [DW_W-1:0]   w_dwell_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;

  assign dwell_last = (r_dwell == DW_W'(DWELL - 1));
  assign slot_last  = (r_slot == SLOT_W'(FRAME_SLOTS - 1));

  // Counters hold at zero while not running so the first scan cycle is slot 0, dwell 0.
  always_comb begin
    w_dwell_nxt = '0;
    w_slot_nxt  = '0;
    if (run) begin
      if (dwell_last) begin
        w_slot_nxt = slot_last ? '0 : r_slot + 1'b1;
      end else begin
        w_dwell_nxt = r_dwell + 1'b1;
        w_slot_nxt  = r_slot;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dwell <= '0;
      r_slot  <= '0;
    end else begin
      r_dwell <= w_dwell_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  assign slot_nxt  = w_slot_nxt;
  assign guard_nxt = (int'(w_dwell_nxt) < GUARD);
  assign last_nxt  = run && (int'(w_slot_nxt) == FRAME_SLOTS - 1) &&
                     (int'(w_dwell_nxt) == DWELL - 1);

endmodule
`default_nettype wire

// File: rtl/led_frame_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_frame_scanner                                                        |
// | Per-frame snapshot of bar/ball positions, time-multiplexed onto LEDout.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_frame_scanner
  import pong_pkg::*;
#(
  parameter int DWELL       = 2000,
  parameter int GUARD       = 1,
  parameter int BAR_LEN     = BAR_LEN_DEF,
  parameter int BAR1_Y      = BAR1_Y_DEF,
  parameter int BAR2_Y      = BAR2_Y_DEF,
  parameter int BALL_SLOTS  = 3,
  parameter int FRAME_SLOTS = 128
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [X_W-1:0]   bar1_x,
  input  logic [X_W-1:0]   bar2_x,
  input  logic [X_W-1:0]   ball_x,
  input  logic [Y_W-1:0]   ball_y,
  input  logic             disp_en,
  output logic [LED_W-1:0] LEDout,
  output logic             frame_done
);

  localparam int c_SLOT_W = cnt_w(FRAME_SLOTS);

  if (FRAME_SLOTS < 2 * BAR_LEN + BALL_SLOTS) begin : g_bad_frame_slots
    $error("FRAME_SLOTS too small for bars and ball");
  end
  if (DWELL < 2 || GUARD >= DWELL || GUARD < 0) begin : g_bad_dwell
    $error("need DWELL >= 2 and 0 <= GUARD < DWELL");
  end
  if (BAR_LEN < 1 || BAR_LEN > 8 || BALL_SLOTS < 1) begin : g_bad_objects
    $error("BAR_LEN must be 1..8 and BALL_SLOTS >= 1");
  end

  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic                w_run;
  logic [c_SLOT_W-1:0] w_slot_nxt;
  logic                w_guard_nxt;
  logic                w_dwell_last;
  logic                w_slot_last;
  logic                w_last_nxt;

  logic [X_W-1:0]   r_snap_bar1, r_snap_bar2, r_snap_ball_x;
  logic [Y_W-1:0]   r_snap_ball_y;
  logic             r_snap_en;
  logic [X_W-1:0]   w_snap_bar1, w_snap_bar2, w_snap_ball_x;
  logic [Y_W-1:0]   w_snap_ball_y;
  logic             w_snap_en;

  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_led_nxt;
  logic             r_frame_done;
  logic             w_frame_done_nxt;
  logic [X_W:0]     w_col;
  int               w_slot_i;

  assign w_run = (r_state == SCAN);

  scan_slot_timer #(
    .DWELL       (DWELL),
    .GUARD       (GUARD),
    .FRAME_SLOTS (FRAME_SLOTS)
  ) u_timer (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .run        (w_run),
    .slot_nxt   (w_slot_nxt),
    .guard_nxt  (w_guard_nxt),
    .dwell_last (w_dwell_last),
    .slot_last  (w_slot_last),
    .last_nxt   (w_last_nxt)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= LATCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = LATCH;
    case (r_state)
      LATCH:   w_state_nxt = SCAN;
      SCAN:    w_state_nxt = (w_dwell_last && w_slot_last) ? LATCH : SCAN;
      default: w_state_nxt = LATCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_snap_bar1   <= '0;
      r_snap_bar2   <= '0;
      r_snap_ball_x <= '0;
      r_snap_ball_y <= '0;
      r_snap_en     <= 1'b0;
    end else if (r_state == LATCH) begin
      r_snap_bar1   <= bar1_x;
      r_snap_bar2   <= bar2_x;
      r_snap_ball_x <= ball_x;
      r_snap_ball_y <= ball_y;
      r_snap_en     <= disp_en;
    end
  end

  // Outputs are registered from next-cycle values, so the snapshot being captured must be seen here.
  assign w_snap_bar1   = (r_state == LATCH) ? bar1_x  : r_snap_bar1;
  assign w_snap_bar2   = (r_state == LATCH) ? bar2_x  : r_snap_bar2;
  assign w_snap_ball_x = (r_state == LATCH) ? ball_x  : r_snap_ball_x;
  assign w_snap_ball_y = (r_state == LATCH) ? ball_y  : r_snap_ball_y;
  assign w_snap_en     = (r_state == LATCH) ? disp_en : r_snap_en;

  always_comb begin
    w_led_nxt        = '0;
    w_col            = '0;
    w_slot_i         = int'(w_slot_nxt);
    w_frame_done_nxt = (w_state_nxt == SCAN) && w_last_nxt;
    if ((w_state_nxt == SCAN) && w_snap_en && !w_guard_nxt) begin
      if (w_slot_i < BAR_LEN) begin
        w_col = {1'b0, w_snap_bar1} + (X_W+1)'(w_slot_i);
        if (!w_col[X_W]) w_led_nxt = led_pixel(LED_BAR, Y_W'(BAR1_Y), w_col[X_W-1:0]);
      end else if (w_slot_i < 2 * BAR_LEN) begin
        w_col = {1'b0, w_snap_bar2} + (X_W+1)'(w_slot_i - BAR_LEN);
        if (!w_col[X_W]) w_led_nxt = led_pixel(LED_BAR, Y_W'(BAR2_Y), w_col[X_W-1:0]);
      end else if (w_slot_i < 2 * BAR_LEN + BALL_SLOTS) begin
        w_led_nxt = led_pixel(LED_BALL, w_snap_ball_y, w_snap_ball_x);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_led        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_led        <= w_led_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign LEDout     = r_led;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_frame_scanner                                                     |
// | Randomised bench for led_frame_scanner against a frame-position model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_led_frame_scanner;

  localparam int DW  = 4;
  localparam int GU  = 1;
  localparam int FS  = 16;
  localparam int BL  = 3;
  localparam int BS  = 3;
  localparam int B1Y = 12;
  localparam int B2Y = 3;
  localparam int PER = 1 + FS * DW;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [2:0] bar1_x, bar2_x, ball_x;
  logic [3:0] ball_y;
  logic       disp_en;
  logic [9:0] LEDout;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int m_p      = 0;
  int s_b1, s_b2, s_bx, s_by;
  bit s_en;
  bit rand_en = 1'b0;
  bit lit_en  = 1'b0;
  logic [9:0] lit [FS];

  led_frame_scanner #(
    .DWELL       (DW),
    .GUARD       (GU),
    .BAR_LEN     (BL),
    .BAR1_Y      (B1Y),
    .BAR2_Y      (B2Y),
    .BALL_SLOTS  (BS),
    .FRAME_SLOTS (FS)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .bar1_x     (bar1_x),
    .bar2_x     (bar2_x),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .disp_en    (disp_en),
    .LEDout     (LEDout),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (frame pos %0d)", tag, got, exp, m_p);
  endtask

  // Expected LEDout at position p of the frame (0 = latch cycle).
  function automatic logic [9:0] exp_led(input int p);
    int k, slot, dw, col;
    logic [9:0] v;
    v = '0;
    if (p != 0 && s_en) begin
      k = p - 1;
      slot = k / DW;
      dw = k % DW;
      if (dw >= GU) begin
        if (slot < BL) begin
          col = s_b1 + slot;
          if (col <= 7) v = {2'b10, 1'b0, 4'(B1Y), 3'(col)};
        end else if (slot < 2 * BL) begin
          col = s_b2 + slot - BL;
          if (col <= 7) v = {2'b10, 1'b0, 4'(B2Y), 3'(col)};
        end else if (slot < 2 * BL + BS) begin
          v = {2'b01, 1'b0, 4'(s_by), 3'(s_bx)};
        end
      end
    end
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    if (m_p == 0) begin
      s_b1 = int'(bar1_x);
      s_b2 = int'(bar2_x);
      s_bx = int'(ball_x);
      s_by = int'(ball_y);
      s_en = disp_en;
    end
    m_p = (m_p + 1) % PER;
    #1;
    if (rand_en && $urandom_range(0, 19) == 0) begin
      bar1_x  = 3'($urandom_range(0, 7));
      bar2_x  = 3'($urandom_range(0, 7));
      ball_x  = 3'($urandom_range(0, 7));
      ball_y  = 4'($urandom_range(0, 15));
      disp_en = ($urandom_range(0, 3) != 0);
    end
    @(negedge CLK);
    check("led", LEDout, exp_led(m_p));
    check("frame_done", frame_done, m_p == PER - 1);
    if (lit_en && (m_p % DW) == 2) check("first_frame", LEDout, lit[m_p / DW]);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_p != target && n < 2 * PER);
    if (m_p != target) check("run_to_timeout", m_p, target);
  endtask

  initial begin
    bar1_x = 3'd0; bar2_x = 3'd5; ball_x = 3'd2; ball_y = 4'd7; disp_en = 1'b1;
    for (int i = 0; i < FS; i++) lit[i] = 10'h000;
    lit[0] = 10'h260; lit[1] = 10'h261; lit[2] = 10'h262;
    lit[3] = 10'h21D; lit[4] = 10'h21E; lit[5] = 10'h21F;
    lit[6] = 10'h13A; lit[7] = 10'h13A; lit[8] = 10'h13A;

    repeat (3) @(negedge CLK);
    #1 RSTn = 1'b1;
    m_p = 0;
    check("rst_led", LEDout, 10'h000);
    check("rst_frame_done", frame_done, 1'b0);

    lit_en = 1'b1;
    repeat (PER) step();
    lit_en = 1'b0;

    run_to(14);
    ball_x = 3'd4;
    run_to(26);
    check("ball_hold", LEDout, 10'h13A);
    run_to(26);
    check("ball_new", LEDout, 10'h13C);

    run_to(0);
    bar1_x = 3'd6;
    run_to(2);
    check("clip_col6", LEDout, 10'h266);
    run_to(6);
    check("clip_col7", LEDout, 10'h267);
    run_to(10);
    check("clip_blank", LEDout, 10'h000);

    run_to(0);
    bar1_x = 3'd0;
    disp_en = 1'b0;
    run_to(10);
    disp_en = 1'b1;
    run_to(26);
    check("dark_ball", LEDout, 10'h000);
    run_to(PER - 1);
    check("dark_frame_done", frame_done, 1'b1);
    run_to(26);
    check("enable_back", LEDout, 10'h13C);

    rand_en = 1'b1;
    repeat (5 * PER) step();
    rand_en = 1'b0;

    run_to(0);
    bar1_x = 3'd0; bar2_x = 3'd5; ball_x = 3'd2; ball_y = 4'd7; disp_en = 1'b1;
    run_to(27);
    check("pre_reset_ball", LEDout, 10'h13A);
    #2 RSTn = 1'b0;
    #1;
    check("async_rst_led", LEDout, 10'h000);
    check("async_rst_frame_done", frame_done, 1'b0);
    @(posedge CLK);
    #1;
    check("rst_hold_led", LEDout, 10'h000);
    @(negedge CLK);
    #1 RSTn = 1'b1;
    m_p = 0;
    lit_en = 1'b1;
    repeat (PER) step();
    lit_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
